regfile_wb_arbiter: RTL and testbench
=====================================

# regfile_wb_arbiter

Shares the single write port of the 32×32 register file between the ALU and load/store writeback paths, and keeps a per-register pending scoreboard that stalls issue on RAW/WAW hazards. Sits between the execute/memory stages and the register file. Its registered write outputs drive the register file's `DataD`, `SelD` and `We` inputs. The register file's `En` stays tied high.

## Interface
Parameters:
- `MaxStreak`, default 3: the maximum number of consecutive LSU grants while the ALU is waiting. Range 1–15.

Ports:
- `Clk` in 1: the only clock.
- `Rst_n` in 1: reset, asynchronous and active-low.
- `AluValid` in 1: ALU writeback request.
- `AluRd` in 5: ALU destination register.
- `AluData` in 32: ALU result.
- `AluReady` out 1: ALU request accepted this cycle.
- `LsuValid` in 1: LSU writeback request.
- `LsuRd` in 5: LSU destination register.
- `LsuData` in 32: load data.
- `LsuReady` out 1: LSU request accepted this cycle.
- `IssueValid` in 1: an instruction with a destination issues this cycle.
- `IssueRd` in 5: destination register of the issuing instruction.
- `ChkRs1` in 5, `ChkRs2` in 5, `ChkRd` in 5: registers of the instruction waiting to issue.
- `Stall` out 1: hazard on the checked instruction.
- `We` out 1: register file write enable.
- `SelD` out 5: register file write select.
- `DataD` out 32: register file write data.

## Operation
Handshake:
- A requester holds Valid high with a stable Rd/Data until it sees Ready high. The transfer happens on the rising edge where Valid and Ready are both high.
- Ready is combinational from the Valid inputs and the streak counter. At most one Ready is high per cycle.
- Ready never depends on the requester's own Data.

Arbitration:
- LSU has priority, because load data is not buffered upstream.
- A streak counter (4 bits) counts LSU grants made while AluValid is high.
- When the counter equals `MaxStreak` and AluValid is high, the ALU is granted and the counter clears.
- The counter also clears on any cycle where AluValid is low or the ALU is granted.

Write stage:
- On an accepted request, the next cycle presents `We=1`, `SelD=Rd`, `DataD=Data`, all registered.
- If Rd is 0, the request is still accepted, but `We` stays 0 and nothing is written.
- With no acceptance, `We=0`. `SelD` and `DataD` hold their last values.

Scoreboard (32-bit pending vector; bit 0 is hardwired 0):
- Set: `IssueValid` with `IssueRd≠0` sets `pending[IssueRd]`.
- Clear: an accepted request clears `pending[Rd]` on the same edge on which it is captured into the write registers. The register file then writes on the following edge.
- Set and clear of the same register on one edge: set wins, because a new writer is in flight.
- `Stall = pending[ChkRs1] | pending[ChkRs2] | pending[ChkRd]`, combinational. Index 0 is never pending.

Usage rules:
- The issue stage issues only when `Stall=0`.
- The issue stage must not assert `IssueValid` while `Stall=1`.
- An accepted writeback with no pending bit set is legal and only writes.

## Timing
- Acceptance to `We` high: 1 cycle. Acceptance to the register file's stored value updating: 2 edges.
- The register file read is registered. An instruction checked the cycle after clear may therefore see `pending=0` one cycle before the data lands.
- To cover that gap, `Stall` also includes `We & (SelD==ChkRs1|ChkRs2)` for nonzero indices, which covers the in-flight write cycle.
- Throughput: one writeback per cycle. Under continuous dual requests, the ALU gets 1 of every `MaxStreak+1` grants.
- Reset (asynchronous, `Rst_n=0`) clears:
  - `We=0`, `SelD=0`, `DataD=0`;
  - all pending bits, so `Stall=0`;
  - the streak counter.
- While in reset, `AluReady` and `LsuReady` are 0.
- Reset mid-operation drops any captured-but-unwritten write. Requesters must re-present after reset.

## Structure
- Shared package `rf_pkg`: `REG_W=32`, `IDX_W=5`, `NUM_REGS=32`, and the writeback request struct (`rd`, `data`).
- One natural sub-module, `wb_scoreboard`: the pending vector with set/clear/check and the in-flight bypass term.
- The arbitration and write registers stay in the top module.

## Test plan
- Reset, then a single ALU write: `AluValid`, `AluRd=5`, `AluData=0xDEADBEEF`. Require `AluReady` the same cycle, then `We=1`, `SelD=5`, `DataD=0xDEADBEEF` the next cycle, and a register file read of x5 returning `0xDEADBEEF`.
- Both requesters valid continuously with `MaxStreak=3`. Require grants in the order L,L,L,A,L,L,L,A, and never both Ready high in one cycle.
- Issue with `IssueRd=7`, then check `ChkRs1=7`. Require `Stall=1` until the LSU writeback to x7 is accepted, and still 1 in the following `We` cycle, then 0.
- Writeback to Rd 0 with data `0x1234`: accepted, `We` stays 0, and `Stall` is never asserted for index 0.
- Same edge: `IssueRd=9` and an accepted writeback with `Rd=9`. Require `pending[9]` to remain 1, so `Stall` stays 1 for `ChkRs2=9`.
- Assert `Rst_n=0` asynchronously mid-stream with pending bits 3 and 4 set and `We=1`. Require `We`, `Stall`, and both Ready outputs to go to 0 immediately, and the scoreboard to be empty after release.

Source files
------------

// File: rtl/rf_pkg.sv
// rf_pkg: shared register-file dimensions and the writeback request record
// used by the writeback arbiter and its scoreboard.
package rf_pkg;

  localparam int unsigned REG_W    = 32;
  localparam int unsigned IDX_W    = 5;
  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned STREAK_W = 4;

  typedef struct packed {
    logic [IDX_W-1:0] rd;
    logic [REG_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/wb_scoreboard.sv
// wb_scoreboard: per-register pending vector for issue hazard detection.
//   i_clk, i_rst_n             clock, async active-low reset
//   i_set_valid, i_set_idx     issue of a writer; marks its destination pending
//   i_clr_valid, i_clr_idx     accepted writeback; clears its destination
//   i_we, i_sel                registered write currently in flight to the RF
//   i_rs1, i_rs2, i_rd         registers of the instruction waiting to issue
//   o_stall                    hazard on the waiting instruction
module wb_scoreboard
  import rf_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_set_valid,
  input  logic [IDX_W-1:0] i_set_idx,
  input  logic             i_clr_valid,
  input  logic [IDX_W-1:0] i_clr_idx,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_sel,
  input  logic [IDX_W-1:0] i_rs1,
  input  logic [IDX_W-1:0] i_rs2,
  input  logic [IDX_W-1:0] i_rd,
  output logic             o_stall
);

  logic [NUM_REGS-1:0] r_pending;
  logic [NUM_REGS-1:0] w_pending_nxt;
  logic                w_bypass;

  // Set is applied after clear so a new writer issued on the same edge
  // keeps the register pending; x0 is never tracked.
  always_comb begin
    w_pending_nxt = r_pending;
    if (i_clr_valid) w_pending_nxt[i_clr_idx] = 1'b0;
    if (i_set_valid) w_pending_nxt[i_set_idx] = 1'b1;
    w_pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_pending <= '0;
    else          r_pending <= w_pending_nxt;
  end

  // The pending bit drops one edge before the RF stores the value; the
  // in-flight write term covers that cycle for the source operands.
  always_comb begin
    w_bypass = i_we && (i_sel != '0) && ((i_sel == i_rs1) || (i_sel == i_rs2));
    o_stall  = r_pending[i_rs1] | r_pending[i_rs2] | r_pending[i_rd] | w_bypass;
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register file write port between the ALU
// and LSU writeback paths and stalls issue on RAW/WAW hazards.
//   Clk, Rst_n                       clock, async active-low reset
//   AluValid/AluRd/AluData/AluReady  ALU writeback handshake
//   LsuValid/LsuRd/LsuData/LsuReady  LSU writeback handshake (priority)
//   IssueValid/IssueRd               issuing instruction's destination
//   ChkRs1/ChkRs2/ChkRd, Stall       hazard check of the waiting instruction
//   We/SelD/DataD                    registered register file write port
module regfile_wb_arbiter
  import rf_pkg::*;
#(
  parameter int unsigned MaxStreak = 3
)(
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             AluValid,
  input  logic [IDX_W-1:0] AluRd,
  input  logic [REG_W-1:0] AluData,
  output logic             AluReady,
  input  logic             LsuValid,
  input  logic [IDX_W-1:0] LsuRd,
  input  logic [REG_W-1:0] LsuData,
  output logic             LsuReady,
  input  logic             IssueValid,
  input  logic [IDX_W-1:0] IssueRd,
  input  logic [IDX_W-1:0] ChkRs1,
  input  logic [IDX_W-1:0] ChkRs2,
  input  logic [IDX_W-1:0] ChkRd,
  output logic             Stall,
  output logic             We,
  output logic [IDX_W-1:0] SelD,
  output logic [REG_W-1:0] DataD
);

  localparam logic [STREAK_W-1:0] STREAK_LIMIT = STREAK_W'(MaxStreak);

  logic [STREAK_W-1:0] r_streak;
  logic                r_we;
  logic [IDX_W-1:0]    r_sel;
  logic [REG_W-1:0]    r_data;

  logic    w_alu_turn;
  logic    w_alu_grant;
  logic    w_lsu_grant;
  logic    w_accept;
  wb_req_t w_alu_req;
  wb_req_t w_lsu_req;
  wb_req_t w_win_req;

  assign w_alu_req = '{rd: AluRd, data: AluData};
  assign w_lsu_req = '{rd: LsuRd, data: LsuData};

  // LSU wins by default; the ALU takes the port once it has lost
  // MaxStreak grants in a row. Ready is forced low while in reset.
  always_comb begin
    w_alu_turn  = AluValid && (r_streak == STREAK_LIMIT);
    w_lsu_grant = Rst_n && LsuValid && !w_alu_turn;
    w_alu_grant = Rst_n && AluValid && (!LsuValid || w_alu_turn);
    w_accept    = w_alu_grant || w_lsu_grant;
    w_win_req   = w_alu_grant ? w_alu_req : w_lsu_req;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)                         r_streak <= '0;
    else if (!AluValid || w_alu_grant)  r_streak <= '0;
    else if (w_lsu_grant)               r_streak <= r_streak + STREAK_W'(1);
  end

  // Writes to x0 are accepted but never enable the register file.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_we   <= 1'b0;
      r_sel  <= '0;
      r_data <= '0;
    end else begin
      r_we <= w_accept && (w_win_req.rd != '0);
      if (w_accept) begin
        r_sel  <= w_win_req.rd;
        r_data <= w_win_req.data;
      end
    end
  end

  wb_scoreboard u_scoreboard (
    .i_clk       (Clk),
    .i_rst_n     (Rst_n),
    .i_set_valid (IssueValid),
    .i_set_idx   (IssueRd),
    .i_clr_valid (w_accept),
    .i_clr_idx   (w_win_req.rd),
    .i_we        (r_we),
    .i_sel       (r_sel),
    .i_rs1       (ChkRs1),
    .i_rs2       (ChkRs2),
    .i_rd        (ChkRd),
    .o_stall     (Stall)
  );

  assign AluReady = w_alu_grant;
  assign LsuReady = w_lsu_grant;
  assign We       = r_we;
  assign SelD     = r_sel;
  assign DataD    = r_data;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed scenarios plus randomized traffic checked
// against a behavioural model of grants, write port and pending registers.
module tb_regfile_wb_arbiter;

  localparam int unsigned MAX_STREAK = 3;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        AluValid, LsuValid, IssueValid;
  logic [4:0]  AluRd, LsuRd, IssueRd, ChkRs1, ChkRs2, ChkRd;
  logic [31:0] AluData, LsuData;
  logic        AluReady, LsuReady, Stall, We;
  logic [4:0]  SelD;
  logic [31:0] DataD;

  always #5 Clk = ~Clk;

  regfile_wb_arbiter #(.MaxStreak(MAX_STREAK)) dut (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .AluValid   (AluValid),
    .AluRd      (AluRd),
    .AluData    (AluData),
    .AluReady   (AluReady),
    .LsuValid   (LsuValid),
    .LsuRd      (LsuRd),
    .LsuData    (LsuData),
    .LsuReady   (LsuReady),
    .IssueValid (IssueValid),
    .IssueRd    (IssueRd),
    .ChkRs1     (ChkRs1),
    .ChkRs2     (ChkRs2),
    .ChkRd      (ChkRd),
    .Stall      (Stall),
    .We         (We),
    .SelD       (SelD),
    .DataD      (DataD)
  );

  // Register file fed by the DUT write port (registered write).
  logic [31:0] rf [32];
  always @(posedge Clk) if (We && SelD != 5'd0) rf[SelD] <= DataD;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state.
  bit          m_pend [32];
  int unsigned m_lost;      // ALU losses in a row while it waited
  bit          m_we;
  logic [4:0]  m_sel;
  logic [31:0] m_data;
  bit          g_alu, g_lsu;

  task automatic m_reset();
    foreach (m_pend[i]) m_pend[i] = 1'b0;
    m_lost = 0;
    m_we   = 1'b0;
    m_sel  = '0;
    m_data = '0;
  endtask

  function automatic bit m_alu_rdy();
    if (!Rst_n || !AluValid) return 1'b0;
    return !LsuValid || (m_lost == MAX_STREAK);
  endfunction

  function automatic bit m_lsu_rdy();
    if (!Rst_n || !LsuValid) return 1'b0;
    return !(AluValid && m_lost == MAX_STREAK);
  endfunction

  function automatic bit m_stall();
    bit inflight;
    inflight = m_we && m_sel != 0 && (m_sel == ChkRs1 || m_sel == ChkRs2);
    return m_pend[ChkRs1] || m_pend[ChkRs2] || m_pend[ChkRd] || inflight;
  endfunction

  task automatic m_clock();
    logic [4:0] rd;
    if (g_alu || g_lsu) begin
      rd     = g_alu ? AluRd : LsuRd;
      m_we   = (rd != 0);
      m_sel  = rd;
      m_data = g_alu ? AluData : LsuData;
      m_pend[rd] = 1'b0;
    end else begin
      m_we = 1'b0;
    end
    if (IssueValid && IssueRd != 0) m_pend[IssueRd] = 1'b1;
    if (!AluValid || g_alu) m_lost = 0;
    else if (g_lsu)         m_lost = m_lost + 1;
  endtask

  // One clock: check combinational outputs, take the edge, check registers.
  task automatic cycle();
    #1;
    g_alu = m_alu_rdy();
    g_lsu = m_lsu_rdy();
    check_eq("alu_ready", AluReady, g_alu);
    check_eq("lsu_ready", LsuReady, g_lsu);
    check_eq("both_ready", AluReady & LsuReady, 0);
    check_eq("stall", Stall, m_stall());
    @(posedge Clk);
    m_clock();
    #1;
    check_eq("we", We, m_we);
    if (m_we) begin
      check_eq("seld", SelD, m_sel);
      check_eq("datad", DataD, m_data);
    end
    @(negedge Clk);
  endtask

  task automatic idle_inputs();
    AluValid = 0; LsuValid = 0; IssueValid = 0;
    AluRd = 0; LsuRd = 0; IssueRd = 0;
    AluData = 0; LsuData = 0;
    ChkRs1 = 0; ChkRs2 = 0; ChkRd = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    string pat;
    pat = "LLLALLLA";
    m_reset();
    idle_inputs();
    Rst_n = 1'b0;
    AluValid = 1; LsuValid = 1;
    #2;
    check_eq("rst_alu_ready", AluReady, 0);
    check_eq("rst_lsu_ready", LsuReady, 0);
    check_eq("rst_we", We, 0);
    check_eq("rst_seld", SelD, 0);
    check_eq("rst_datad", DataD, 0);
    check_eq("rst_stall", Stall, 0);
    @(negedge Clk);
    idle_inputs();
    @(negedge Clk);
    Rst_n = 1'b1;
    cycle();

    // Single ALU write to x5.
    AluValid = 1; AluRd = 5; AluData = 32'hDEADBEEF;
    #1 check_eq("alu_single_ready", AluReady, 1);
    cycle();
    check_eq("alu_single_we", We, 1);
    check_eq("alu_single_sel", SelD, 5);
    check_eq("alu_single_data", DataD, 32'hDEADBEEF);
    AluValid = 0;
    cycle();
    check_eq("rf_x5", rf[5], 32'hDEADBEEF);

    // Continuous dual requests: fixed grant pattern.
    AluValid = 1; AluRd = 1; AluData = 32'h1111_0001;
    LsuValid = 1; LsuRd = 2; LsuData = 32'h2222_0002;
    for (int k = 0; k < 8; k++) begin
      #1 check_eq("streak_grant", {AluReady, LsuReady}, (pat[k] == "A") ? 2'b10 : 2'b01);
      cycle();
    end
    AluValid = 0; LsuValid = 0;
    cycle();

    // RAW hazard on x7 cleared by an LSU writeback.
    IssueValid = 1; IssueRd = 7;
    cycle();
    IssueValid = 0; ChkRs1 = 7;
    repeat (2) begin
      #1 check_eq("raw_wait", Stall, 1);
      cycle();
    end
    LsuValid = 1; LsuRd = 7; LsuData = 32'h0BADF00D;
    #1 check_eq("raw_accept_stall", Stall, 1);
    check_eq("raw_accept_ready", LsuReady, 1);
    cycle();
    LsuValid = 0;
    #1 check_eq("raw_inflight", Stall, 1);
    check_eq("raw_inflight_we", We, 1);
    cycle();
    #1 check_eq("raw_clear", Stall, 0);
    ChkRs1 = 0;

    // Writeback and issue targeting x0.
    AluValid = 1; AluRd = 0; AluData = 32'h1234;
    IssueValid = 1; IssueRd = 0;
    #1 check_eq("rd0_ready", AluReady, 1);
    check_eq("rd0_stall_pre", Stall, 0);
    cycle();
    AluValid = 0; IssueValid = 0;
    check_eq("rd0_we", We, 0);
    #1 check_eq("rd0_stall", Stall, 0);
    cycle();

    // Issue and writeback to x9 on the same edge: set wins.
    IssueValid = 1; IssueRd = 9;
    AluValid = 1; AluRd = 9; AluData = 32'h9999_0009;
    #1 check_eq("same_edge_ready", AluReady, 1);
    cycle();
    IssueValid = 0; AluValid = 0; ChkRs2 = 9;
    cycle();
    #1 check_eq("same_edge_pending", Stall, 1);
    LsuValid = 1; LsuRd = 9; LsuData = 32'h9999_1009;
    cycle();
    LsuValid = 0;
    cycle();
    #1 check_eq("same_edge_cleanup", Stall, 0);
    ChkRs2 = 0;

    // Randomized traffic with legal handshakes and issue.
    for (int n = 0; n < 400; n++) begin
      if (!AluValid || g_alu) begin
        AluValid = ($urandom_range(0, 2) != 0);
        AluRd    = 5'($urandom_range(0, 7));
        AluData  = $urandom;
      end
      if (!LsuValid || g_lsu) begin
        LsuValid = ($urandom_range(0, 2) != 0);
        LsuRd    = 5'($urandom_range(0, 7));
        LsuData  = $urandom;
      end
      ChkRs1 = 5'($urandom_range(0, 7));
      ChkRs2 = 5'($urandom_range(0, 7));
      ChkRd  = 5'($urandom_range(0, 7));
      IssueRd    = ChkRd;
      IssueValid = !m_stall() && ($urandom_range(0, 1) != 0);
      cycle();
    end

    // Asynchronous reset mid-stream.
    idle_inputs();
    cycle();
    IssueValid = 1; IssueRd = 3;
    cycle();
    IssueRd = 4; AluValid = 1; AluRd = 10; AluData = 32'hAAAA_000A;
    cycle();
    IssueValid = 0;
    AluRd = 11; AluData = 32'hAAAA_000B;
    LsuValid = 1; LsuRd = 12; LsuData = 32'hBBBB_000C;
    ChkRs1 = 3; ChkRs2 = 4;
    #1 check_eq("prerst_we", We, 1);
    check_eq("prerst_stall", Stall, 1);
    #1 Rst_n = 1'b0;
    m_reset();
    #1;
    check_eq("midrst_we", We, 0);
    check_eq("midrst_stall", Stall, 0);
    check_eq("midrst_alu_ready", AluReady, 0);
    check_eq("midrst_lsu_ready", LsuReady, 0);
    @(negedge Clk);
    AluValid = 0; LsuValid = 0;
    @(negedge Clk);
    Rst_n = 1'b1;
    for (int i = 0; i < 32; i++) begin
      ChkRs1 = 5'(i); ChkRs2 = 5'(i); ChkRd = 5'(i);
      #1 check_eq("postrst_empty", Stall, 0);
    end
    @(negedge Clk);
    ChkRs1 = 3; ChkRs2 = 4; ChkRd = 0;
    cycle();
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
